// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding
// and memory port-select codes.
package dmem_arb_pkg;

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_e;

  localparam logic SEL_CPU = 1'b0;
  localparam logic SEL_DMA = 1'b1;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU priority with a starvation counter
// that forces bounded DMA bursts, stalling the pipeline while DMA owns memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int DMA_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = (DMA_BURST > 1) ? $clog2(DMA_BURST) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(DMA_BURST - 1);

  arb_state_e        state_reg, state_next;
  logic [WW-1:0]     wait_reg, wait_next;
  logic [BW-1:0]     beat_reg, beat_next;
  logic              dma_rvalid_reg;
  logic [DATA_W-1:0] dma_rdata_reg;

  logic cpu_grant, dma_grant, sel;

  always_comb begin
    cpu_grant  = 1'b0;
    dma_grant  = 1'b0;
    state_next = state_reg;
    wait_next  = wait_reg;
    beat_next  = beat_reg;
    case (state_reg)
      S_CPU: begin
        if (cpu_req)      cpu_grant = 1'b1;
        else if (dma_req) dma_grant = 1'b1;

        // A denied DMA request ages; the MAX_WAIT-th denial forces ownership.
        if (dma_grant) begin
          wait_next = '0;
        end else if (cpu_req && dma_req) begin
          if (wait_reg == WAIT_LAST) begin
            state_next = S_DMA;
            wait_next  = '0;
            beat_next  = '0;
          end else begin
            wait_next = wait_reg + WW'(1);
          end
        end
      end
      S_DMA: begin
        if (dma_req)      dma_grant = 1'b1;
        else if (cpu_req) cpu_grant = 1'b1;

        wait_next = '0;
        if (!dma_req || beat_reg == BEAT_LAST) begin
          state_next = S_CPU;
          beat_next  = '0;
        end else begin
          beat_next = beat_reg + BW'(1);
        end
      end
      default: begin
        state_next = S_CPU;
        wait_next  = '0;
        beat_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_CPU;
      wait_reg       <= '0;
      beat_reg       <= '0;
      dma_rvalid_reg <= 1'b0;
      dma_rdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      wait_reg       <= wait_next;
      beat_reg       <= beat_next;
      dma_rvalid_reg <= dma_grant & ~dma_we;
      if (dma_grant && !dma_we) dma_rdata_reg <= mem_rdata;
    end
  end

  // CPU port drives the memory whenever DMA is not granted, including idle.
  assign sel       = dma_grant ? SEL_DMA : SEL_CPU;
  assign mem_addr  = (sel == SEL_DMA) ? dma_addr : cpu_addr;
  assign mem_wdata = (sel == SEL_DMA) ? dma_wdata : cpu_wdata;
  assign mem_write = (cpu_grant & cpu_we) | (dma_grant & dma_we);
  assign mem_read  = (cpu_grant & ~cpu_we) | (dma_grant & ~dma_we);

  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = cpu_req & ~cpu_grant;
  assign dma_gnt    = dma_req & dma_grant;
  assign dma_rvalid = dma_rvalid_reg;
  assign dma_rdata  = dma_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a counting model
// of the arbitration rules, with a small behavioural memory behind it.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = 4;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write, mem_read;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW), .DMA_BURST(DB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  // Behavioural single-port memory: combinational read, write at clock edge.
  logic [DW-1:0] mem_arr [64];
  assign mem_rdata = mem_arr[mem_addr[5:0]];
  always @(posedge clk) if (mem_write) mem_arr[mem_addr[5:0]] <= mem_wdata;

  // Reference model: shadow memory plus "DMA has been starved" bookkeeping.
  logic [DW-1:0] ref_mem [64];
  bit            m_dma_mode;
  int            m_denied, m_beats;
  bit            m_rvalid;
  logic [DW-1:0] m_rdata;

  int checks = 0, errors = 0;
  logic          obs_gnt, obs_stall, obs_rvalid;
  logic [DW-1:0] obs_cpu_rdata, obs_dma_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dma_mode = 0; m_denied = 0; m_beats = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    bit eg_cpu, eg_dma;
    @(negedge clk);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    #1;
    if (!m_dma_mode) begin eg_cpu = cr; eg_dma = !cr && dr; end
    else             begin eg_dma = dr; eg_cpu = !dr && cr; end
    chk("cpu_stall", cpu_stall, cr && !eg_cpu);
    chk("dma_gnt", dma_gnt, eg_dma);
    chk("mem_write", mem_write, (eg_cpu && cw) || (eg_dma && dw));
    chk("mem_read", mem_read, (eg_cpu && !cw) || (eg_dma && !dw));
    chk("mem_addr", mem_addr, eg_dma ? da : ca);
    if ((eg_cpu && cw) || (eg_dma && dw)) chk("mem_wdata", mem_wdata, eg_dma ? dd : cd);
    if (eg_cpu && !cw) chk("cpu_rdata", cpu_rdata, ref_mem[ca[5:0]]);
    chk("dma_rvalid", dma_rvalid, m_rvalid);
    chk("dma_rdata", dma_rdata, m_rdata);
    obs_gnt = dma_gnt; obs_stall = cpu_stall; obs_rvalid = dma_rvalid;
    obs_cpu_rdata = cpu_rdata; obs_dma_rdata = dma_rdata;
    $display("t=%0t cpu(req=%0b we=%0b a=%0h) dma(req=%0b we=%0b a=%0h) stall=%0b gnt=%0b rv=%0b rd=%h",
             $time, cr, cw, ca, dr, dw, da, cpu_stall, dma_gnt, dma_rvalid, dma_rdata);
    @(posedge clk);
    if (eg_dma && !dw) begin m_rvalid = 1; m_rdata = ref_mem[da[5:0]]; end
    else m_rvalid = 0;
    if (eg_cpu && cw) ref_mem[ca[5:0]] = cd;
    if (eg_dma && dw) ref_mem[da[5:0]] = dd;
    if (!m_dma_mode) begin
      if (eg_dma) m_denied = 0;
      else if (cr && dr) begin
        m_denied++;
        if (m_denied == MW) begin m_dma_mode = 1; m_denied = 0; m_beats = 0; end
      end
    end else begin
      if (!dr) begin m_dma_mode = 0; m_beats = 0; end
      else begin
        m_beats++;
        if (m_beats == DB) begin m_dma_mode = 0; m_beats = 0; end
      end
    end
  endtask

  // Asynchronous reset in mid-cycle with both requesters active.
  task automatic do_reset();
    @(negedge clk);
    chk("pre_rst_rvalid", dma_rvalid, m_rvalid);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'd3; dma_req = 1; dma_we = 0; dma_addr = 32'd4;
    #1;
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_rvalid", dma_rvalid, 1'b0);
    chk("rst_rdata", dma_rdata, '0);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_gnt", dma_gnt, 1'b0);
    chk("rst_mem_read", mem_read, 1'b1);
    chk("rst_mem_addr", mem_addr, 32'd3);
    $display("t=%0t reset asserted", $time);
    @(negedge clk);
    cpu_req = 0; dma_req = 0;
    rst_n = 1;
  endtask

  initial begin
    logic [31:0] ra, rd, pa, pd;
    logic        rcr, rcw, pr, pw, pending;
    model_reset();

    // 1: reset
    do_reset();

    // Preload every word through the DMA port so memory and model agree.
    for (int i = 0; i < 64; i++) step(0, 0, 0, 0, 1, 1, i, $urandom);

    // 2: DMA write then read-back with the CPU idle
    step(0, 0, 0, 0, 1, 1, 5, 32'hDEADBEEF);
    chk("t2_gnt_wr", obs_gnt, 1'b1);
    step(0, 0, 0, 0, 1, 0, 5, 0);
    chk("t2_gnt_rd", obs_gnt, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_rvalid", obs_rvalid, 1'b1);
    chk("t2_rdata", obs_dma_rdata, 32'hDEADBEEF);

    // 3: both requesting continuously -> 4 CPU, 8 DMA, repeating
    do_reset();
    for (int i = 0; i < 36; i++) begin
      step(1, 0, 32'd10, 0, 1, 0, 32'd20, 0);
      chk("t3_pattern", obs_gnt, (i % 12) >= 4);
    end

    // 4: DMA drops out after 3 beats -> CPU same cycle, back in CPU state
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 0, 32'd11, 0, 1, 0, 32'd21, 0);
    step(1, 0, 32'd11, 0, 0, 0, 0, 0);
    chk("t4_stall", obs_stall, 1'b0);
    step(1, 0, 32'd11, 0, 1, 0, 32'd21, 0);
    chk("t4_cpu_state", obs_gnt, 1'b0);

    // 5: CPU read with zero added latency
    step(0, 0, 0, 0, 1, 1, 7, 32'h12345678);
    step(1, 0, 7, 0, 0, 0, 0, 0);
    chk("t5_rdata", obs_cpu_rdata, 32'h12345678);
    chk("t5_stall", obs_stall, 1'b0);

    // 6: reset the cycle after a DMA read grant inside a forced burst
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 32'd12, 0, 1, 0, 32'd7, 0);
    do_reset();
    step(1, 0, 32'd12, 0, 1, 0, 32'd7, 0);
    chk("t6_cpu_first", obs_stall, 1'b0);

    // Randomized traffic; a pending DMA request keeps its fields until granted.
    pending = 0; pr = 0; pw = 0; pa = 0; pd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pending) begin
        pr = ($urandom_range(0, 3) != 0);
        pw = $urandom_range(0, 1);
        pa = $urandom_range(0, 63);
        pd = $urandom;
      end
      rcr = ($urandom_range(0, 9) < 7);
      rcw = $urandom_range(0, 1);
      ra  = $urandom_range(0, 63);
      rd  = $urandom;
      step(rcr, rcw, ra, rd, pr, pw, pa, pd);
      pending = pr && !obs_gnt;
      if (i == 200) do_reset();
      if (i == 200) pending = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the pipeline MEM stage (CPU port) and a DMA/loader port used for program-data preload and debug readback. The CPU has priority, but a starvation counter and bounded DMA bursts guarantee DMA progress. When DMA owns the memory, the arbiter stalls the pipeline. It sits between the MEM stage / DMA engine and the data memory's address, write-data, write-enable and read-enable inputs.

Parameters:
DATA_W, 32, data width of all data buses
ADDR_W, 32, address width passed through to memory
MAX_WAIT, 4, consecutive denied DMA-request cycles before DMA is forced ownership (≥1)
DMA_BURST, 8, maximum consecutive DMA grants per forced-ownership window (≥1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  MEM stage access request (MemRead | MemWrite)
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data; combinational pass-through of mem_rdata
cpu_stall  out  1  freeze the pipeline; CPU request not granted this cycle
dma_req  in  1  DMA access request; held with its fields stable until dma_gnt
dma_we  in  1  1 = write, 0 = read
dma_addr  in  ADDR_W  DMA word address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  DMA access performed this cycle
dma_rvalid  out  1  registered; dma_rdata is valid (one cycle after a DMA read grant)
dma_rdata  out  DATA_W  registered DMA read data
mem_addr  out  ADDR_W  to memory address
mem_wdata  out  DATA_W  to memory writeData
mem_write  out  1  to memory MemWrite
mem_read  out  1  to memory MemRead
mem_rdata  in  DATA_W  from memory readData (combinational)

Behaviour:
- States: S_CPU (reset) and S_DMA. Registers: state, wait_cnt (0..MAX_WAIT), beat_cnt (0..DMA_BURST-1), dma_rvalid, dma_rdata.
- Reset (asynchronous, rst_n=0): state=S_CPU, wait_cnt=0, beat_cnt=0, dma_rvalid=0, dma_rdata=0. Combinational outputs follow the S_CPU rules. Reset mid-burst abandons the burst and discards any pending rvalid.
- Grant (combinational):
  - S_CPU: cpu_req=1 grants CPU. Otherwise dma_req=1 grants DMA (idle-slot steal).
  - S_DMA: dma_req=1 grants DMA. Otherwise cpu_req=1 grants CPU in the same cycle, with no bubble.
- cpu_stall = cpu_req & ~cpu_granted. dma_gnt = dma_req & dma_granted.
- Memory drive:
  - mem_addr/mem_wdata are muxed from the granted port; the CPU port is selected when nothing is granted.
  - mem_write = granted & we; mem_read = granted & ~we.
  - A write commits at the clk edge ending the grant cycle.
- CPU read data: cpu_rdata = mem_rdata, zero added latency.
- DMA read data: on a DMA read grant, mem_rdata is captured into dma_rdata and dma_rvalid=1 on the next cycle; otherwise dma_rvalid=0. dma_rdata holds its value between reads.
- wait_cnt (S_CPU only):
  - Increments each cycle with dma_req=1 and cpu_req=1 (DMA denied).
  - Clears on any dma_gnt.
  - When wait_cnt==MAX_WAIT-1 and DMA is denied again: next state S_DMA, wait_cnt=0, beat_cnt=0.
- beat_cnt (S_DMA only): increments on each dma_gnt.
- Leaving S_DMA: return to S_CPU (beat_cnt=0) after the grant with beat_cnt==DMA_BURST-1, or on the first cycle with dma_req=0.
- Simultaneous requests in S_CPU: CPU wins unless already in S_DMA; the forced switch takes effect the following cycle.
- Address/data are not range-checked; the memory indexes as it does today.
- No combinational path from dma_* inputs to dma_rvalid or dma_rdata.

Decomposition:
- Shared package dmem_arb_pkg:
  - state encoding constants S_CPU=1'b0, S_DMA=1'b1
  - port-select constants SEL_CPU, SEL_DMA
- Single module. The grant/mux logic is small enough to stay inline; no sub-module.

Test Plan:
1. Reset with cpu_req=1, dma_req=1 held → cpu_stall=0, dma_gnt=0, dma_rvalid=0, dma_rdata=0, mem_read=1 for CPU address.
2. cpu_req=0, DMA write addr 5 data 0xDEADBEEF, then DMA read addr 5 → dma_gnt=1 both cycles, mem_write=1 then mem_read=1, dma_rvalid=1 with dma_rdata=0xDEADBEEF one cycle after the read grant.
3. cpu_req and dma_req held high continuously (MAX_WAIT=4, DMA_BURST=8):
   - CPU is granted for 4 cycles, then DMA for 8 cycles with cpu_stall=1 throughout, then CPU for 4 cycles; the pattern repeats.
4. In S_DMA after 3 beats, dma_req drops → CPU is granted that same cycle, cpu_stall=0, and the state returns to S_CPU with beat_cnt=0.
5. CPU read of addr 7 (preloaded with 0x12345678) with dma_req=0 → cpu_rdata=0x12345678 in the same cycle, cpu_stall=0.
6. rst_n pulsed low mid-burst on the cycle after a DMA read grant → dma_rvalid=0 immediately, state S_CPU, counters 0; the CPU is granted on the first cycle after release.
